// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback arbiter bus bundle; forwarding ports under REGFILE_WB_FWD_EN
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                   in0_valid;
  logic [ADDR_W-1:0]      in0_addr;
  logic [DATA_W-1:0]      in0_data;
  logic                   in0_ready;
  logic                   in1_valid;
  logic [ADDR_W-1:0]      in1_addr;
  logic [DATA_W-1:0]      in1_data;
  logic                   in1_ready;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [2**ADDR_W-1:0]   pend_mask;
  logic                   idle;
`ifdef REGFILE_WB_FWD_EN
  logic [ADDR_W-1:0]      fwd_raddr1;
  logic [ADDR_W-1:0]      fwd_raddr2;
  logic                   fwd_hit1;
  logic                   fwd_hit2;
  logic [DATA_W-1:0]      fwd_data1;
  logic [DATA_W-1:0]      fwd_data2;
`endif

  // Arbiter side
  modport slave (
`ifdef REGFILE_WB_FWD_EN
    input  fwd_raddr1, fwd_raddr2,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    input  in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
    output in0_ready, in1_ready, rf_we, rf_waddr, rf_wdata, pend_mask, idle
  );

  // Requester / register-file side
  modport master (
`ifdef REGFILE_WB_FWD_EN
    output fwd_raddr1, fwd_raddr2,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    output in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
    input  in0_ready, in1_ready, rf_we, rf_waddr, rf_wdata, pend_mask, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file writeback arbiter; optional forwarding via REGFILE_WB_FWD_EN
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] X0 = '0;

  logic              buf0_valid, buf1_valid;
  logic [ADDR_W-1:0] buf0_addr, buf1_addr;
  logic [DATA_W-1:0] buf0_data, buf1_data;
  logic              age;     // 1: buffer 1 holds the older entry
  logic              rr;      // tie-break pointer for same-edge loads
  logic [NREG-1:0]   pend_q;

  logic              grant0, grant1, take0, take1;
  logic              next0_valid, next1_valid;
  logic [ADDR_W-1:0] next0_addr, next1_addr;
  logic [NREG-1:0]   pend_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we;

  // Grant depends only on buffer state: a lone entry wins, otherwise the older one.
  always_comb begin
    grant0 = buf0_valid && (!buf1_valid || !age);
    grant1 = buf1_valid && (!buf0_valid || age);
  end

  assign bus.in0_ready = !buf0_valid || grant0;
  assign bus.in1_ready = !buf1_valid || grant1;
  assign take0 = bus.in0_valid && bus.in0_ready;
  assign take1 = bus.in1_valid && bus.in1_ready;

  // Post-edge buffer contents, used to precompute the registered pending mask.
  always_comb begin
    next0_valid = take0 || (buf0_valid && !grant0);
    next1_valid = take1 || (buf1_valid && !grant1);
    next0_addr  = take0 ? bus.in0_addr : buf0_addr;
    next1_addr  = take1 ? bus.in1_addr : buf1_addr;
    pend_d = '0;
    if (next0_valid && next0_addr != X0) pend_d[next0_addr] = 1'b1;
    if (next1_valid && next1_addr != X0) pend_d[next1_addr] = 1'b1;
  end

  // Buffer load/drain, age tracking and tie-break pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf0_valid <= 1'b0;
      buf1_valid <= 1'b0;
      buf0_addr  <= '0;
      buf1_addr  <= '0;
      buf0_data  <= '0;
      buf1_data  <= '0;
      age        <= 1'b0;
      rr         <= 1'b0;
      pend_q     <= '0;
    end else begin
      buf0_valid <= next0_valid;
      buf1_valid <= next1_valid;
      if (take0) begin
        buf0_addr <= bus.in0_addr;
        buf0_data <= bus.in0_data;
      end
      if (take1) begin
        buf1_addr <= bus.in1_addr;
        buf1_data <= bus.in1_data;
      end
      // A fresh load is younger than whatever the other buffer still holds.
      if (take0 && take1) begin
        age <= rr;
        rr  <= !rr;
      end else if (take0) begin
        age <= 1'b1;
      end else if (take1) begin
        age <= 1'b0;
      end
      pend_q <= pend_d;
    end
  end

  // Granted entry drives the write port; x0 targets and the reset cycle write nothing.
  always_comb begin
    sel_addr = grant1 ? buf1_addr : buf0_addr;
    sel_data = grant1 ? buf1_data : buf0_data;
    we       = !rst && (grant0 || grant1) && (sel_addr != X0);
  end

  assign bus.rf_we     = we;
  assign bus.rf_waddr  = we ? sel_addr : '0;
  assign bus.rf_wdata  = we ? sel_data : '0;
  assign bus.pend_mask = pend_q;
  assign bus.idle      = !buf0_valid && !buf1_valid;

`ifdef REGFILE_WB_FWD_EN
  // Returns {hit, data}; when both buffers match, the younger entry's data wins.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] raddr);
    logic m0, m1;
    m0 = buf0_valid && (buf0_addr != X0) && (buf0_addr == raddr);
    m1 = buf1_valid && (buf1_addr != X0) && (buf1_addr == raddr);
    if (m0 && m1)  fwd_lookup = {1'b1, age ? buf0_data : buf1_data};
    else if (m0)   fwd_lookup = {1'b1, buf0_data};
    else if (m1)   fwd_lookup = {1'b1, buf1_data};
    else           fwd_lookup = '0;
  endfunction

  assign {bus.fwd_hit1, bus.fwd_data1} = fwd_lookup(bus.fwd_raddr1);
  assign {bus.fwd_hit2, bus.fwd_data2} = fwd_lookup(bus.fwd_raddr2);
`endif
endmodule
